// File: rtl/ldfifo_seq_pkg.sv
// Shared types and sizing helpers for the skewed FIFO-bank sequencer.
//   seq_state_t : sequencer FSM states
//   t_width()   : width of the skew counter for a given DEPTH/ROWS
package ldfifo_seq_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STREAM = 3'd2,
      FLUSH  = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

   // Skew counter must hold 0 .. DEPTH+ROWS-1 without wrapping.
   function automatic int unsigned t_width(input int unsigned depth, input int unsigned rows);
      return (depth + rows > 1) ? $clog2(depth + rows) : 1;
   endfunction

endpackage

// File: rtl/skew_row_ctrl.sv
// Per-row pop window decode and read-valid re-timing.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   i_t          : shared skew counter
//   i_active     : sequencer is streaming and not aborting this cycle
//   i_stall      : downstream back-pressure, suppresses the pop
//   o_pop        : pop strobe for this row's FIFO (combinational)
//   o_row_valid  : o_pop delayed one cycle, aligned with the FIFO's registered data_out
module skew_row_ctrl #(
   parameter int unsigned ROW   = 0,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [TW-1:0] i_t,
   input  logic          i_active,
   input  logic          i_stall,
   output logic          o_pop,
   output logic          o_row_valid
);

   logic [TW-1:0] w_rel;
   logic          r_row_valid;

   // t - ROW wraps to a value >= DEPTH when t < ROW, so one compare covers both window edges.
   assign w_rel = i_t - TW'(ROW);
   assign o_pop = i_active & ~i_stall & (w_rel < TW'(DEPTH));

   // Valid follows the pop regardless of a later stall.
   always_ff @(posedge clk) begin
      if (!rst) r_row_valid <= 1'b0;
      else      r_row_valid <= o_pop;
   end

   assign o_row_valid = r_row_valid;

endmodule

// File: rtl/ldfifo_skew_sequencer.sv
// Sequencer for a bank of ROWS parallel-load FIFOs feeding a systolic array:
// one parallel-load strobe, then diagonally skewed pops of DEPTH entries per row.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   start         : begin a run (IDLE only)
//   stall         : freeze skew counter and suppress pops
//   abort         : cancel an active run, pulses fifo_rst_ptr
//   fifo_empty    : per-row FIFO empty flags (error detection only)
//   fifo_data     : per-row FIFO data_out, packed ROWS x DATAWIDTH
//   fifo_load     : parallel-load strobe to all FIFOs
//   fifo_rst_ptr  : pointer-reset strobe to all FIFOs (combinational with abort)
//   fifo_pop      : per-row pop (combinational with stall/abort)
//   row_data      : fifo_data passed through
//   row_valid     : per-row data valid
//   busy, done    : run in progress / one-cycle completion pulse
//   err           : sticky pop-while-empty flag
module ldfifo_skew_sequencer
   import ldfifo_seq_pkg::*;
#(
   parameter int unsigned ROWS      = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DATAWIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      stall,
   input  logic                      abort,
   input  logic [ROWS-1:0]           fifo_empty,
   input  logic [ROWS*DATAWIDTH-1:0] fifo_data,
   output logic                      fifo_load,
   output logic                      fifo_rst_ptr,
   output logic [ROWS-1:0]           fifo_pop,
   output logic [ROWS*DATAWIDTH-1:0] row_data,
   output logic [ROWS-1:0]           row_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int unsigned TW     = t_width(DEPTH, ROWS);
   localparam int unsigned T_LAST = DEPTH + ROWS - 2;

   seq_state_t    r_state, w_state_nxt;
   logic [TW-1:0] r_t, w_t_nxt;
   logic          r_fifo_load, r_busy, r_done, r_err;
   logic          w_active, w_rst_ptr, w_err_clr, w_err_hit;

   // State, skew counter and registered strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_t         <= '0;
         r_fifo_load <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_t         <= w_t_nxt;
         r_fifo_load <= (w_state_nxt == LOAD);
         r_busy      <= (w_state_nxt != IDLE);
         r_done      <= (w_state_nxt == DONE);
         if (w_err_clr)      r_err <= 1'b0;
         else if (w_err_hit) r_err <= 1'b1;
      end
   end

   // Next-state and combinational controls.
   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      w_active    = 1'b0;
      w_rst_ptr   = 1'b0;
      w_err_clr   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = LOAD;
               w_err_clr   = 1'b1;
            end
         end
         LOAD: begin
            w_t_nxt = '0;
            if (abort) begin
               w_state_nxt = IDLE;
               w_rst_ptr   = 1'b1;
            end else begin
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_rst_ptr   = 1'b1;
               w_t_nxt     = '0;
            end else begin
               w_active = 1'b1;
               if (!stall) begin
                  if (r_t == TW'(T_LAST)) begin
                     w_state_nxt = FLUSH;
                     w_t_nxt     = '0;
                  end else begin
                     w_t_nxt = r_t + TW'(1);
                  end
               end
            end
         end
         FLUSH: begin
            w_state_nxt = abort ? IDLE : DONE;
            w_rst_ptr   = abort;
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_rst_ptr   = abort;
         end
         default: begin
            w_state_nxt = IDLE;
            w_t_nxt     = '0;
         end
      endcase
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      skew_row_ctrl #(
         .ROW   (r),
         .DEPTH (DEPTH),
         .TW    (TW)
      ) u_row (
         .clk         (clk),
         .rst         (rst),
         .i_t         (r_t),
         .i_active    (w_active),
         .i_stall     (stall),
         .o_pop       (fifo_pop[r]),
         .o_row_valid (row_valid[r])
      );
   end

   // Empty flag is unreliable for termination after a parallel load; it only flags errors.
   assign w_err_hit    = |(fifo_pop & fifo_empty);

   assign row_data     = fifo_data;
   assign fifo_load    = r_fifo_load;
   assign fifo_rst_ptr = w_rst_ptr;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;

endmodule

// File: tb/tb_ldfifo_skew_sequencer.sv
module tb_ldfifo_skew_sequencer;

   localparam int unsigned ROWS = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW = 8;

   logic              clk = 1'b0;
   logic              rst, start, stall, abort;
   logic [ROWS-1:0]   fifo_empty;
   logic [ROWS*DW-1:0] fifo_data;
   logic              fifo_load, fifo_rst_ptr, busy, done, err;
   logic [ROWS-1:0]   fifo_pop, row_valid;
   logic [ROWS*DW-1:0] row_data;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_pop [0:15];

   always #5 clk = ~clk;

   ldfifo_skew_sequencer #(.ROWS(ROWS), .DEPTH(DEPTH), .DATAWIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stall        (stall),
      .abort        (abort),
      .fifo_empty   (fifo_empty),
      .fifo_data    (fifo_data),
      .fifo_load    (fifo_load),
      .fifo_rst_ptr (fifo_rst_ptr),
      .fifo_pop     (fifo_pop),
      .row_data     (row_data),
      .row_valid    (row_valid),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, check every output mid-cycle, advance to the next negedge.
   task automatic step(input string tag, input logic s, input logic st, input logic ab,
                       input logic r, input logic [3:0] emp,
                       input logic e_load, input logic e_rst, input logic [3:0] e_pop,
                       input logic [3:0] e_val, input logic e_busy, input logic e_done,
                       input logic e_err);
      logic [31:0] d;
      d          = $urandom();
      start      = s;
      stall      = st;
      abort      = ab;
      rst        = r;
      fifo_empty = emp;
      fifo_data  = d;
      #1;
      chk({tag, " load"},    32'(fifo_load),    32'(e_load));
      chk({tag, " rst_ptr"}, 32'(fifo_rst_ptr), 32'(e_rst));
      chk({tag, " pop"},     32'(fifo_pop),     32'(e_pop));
      chk({tag, " valid"},   32'(row_valid),    32'(e_val));
      chk({tag, " busy"},    32'(busy),         32'(e_busy));
      chk({tag, " done"},    32'(done),         32'(e_done));
      chk({tag, " err"},     32'(err),          32'(e_err));
      chk({tag, " data"},    32'(row_data),     d);
      @(negedge clk);
   endtask

   // Run a directed sequence against exp_pop; cycle 0 is the cycle in which start is sampled.
   task automatic run_tab(input string tag, input int n, input int done_c,
                          input logic [15:0] smask, input logic [15:0] stmask,
                          input int abort_at, input int rst_at, input logic [3:0] emp,
                          input logic err_c0, input int err_from);
      logic [3:0] prev;
      logic [3:0] p;
      logic       ab, e_err;
      prev = 4'h0;
      for (int c = 0; c < n; c++) begin
         ab    = (c == abort_at);
         p     = ab ? 4'h0 : exp_pop[c];
         e_err = (c == 0) ? err_c0 : (c >= err_from);
         step($sformatf("%s c%0d", tag, c), smask[c], stmask[c], ab, (c != rst_at), emp,
              (c == 1), ab, p, prev, (c >= 1 && c <= done_c && c <= abort_at),
              (c == done_c), e_err);
         prev = p;
      end
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      stall      = 1'b0;
      abort      = 1'b0;
      fifo_empty = '0;
      fifo_data  = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset state, held in reset with a stray start.
      step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      step("reset2", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

      // Plain run: pops 1,3,7,F,E,C,8 in cycles 2-8, done in cycle 10.
      exp_pop = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC,
                  4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      run_tab("run", 12, 10, 16'h0001, 16'h0000, 99, 99, 4'h0, 1'b0, 99);

      // Stall in cycles 4-5: the pattern resumes at 7 in cycle 6, done in cycle 12.
      exp_pop = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h7, 4'hF,
                  4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      run_tab("stall", 14, 12, 16'h0001, 16'h0030, 99, 99, 4'h0, 1'b0, 99);

      // Abort in cycle 5, then a fresh start in cycle 6.
      exp_pop = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC,
                  4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
      run_tab("abort", 6, 99, 16'h0001, 16'h0000, 5, 99, 4'h0, 1'b0, 99);
      run_tab("after_abort", 12, 10, 16'h0001, 16'h0000, 99, 99, 4'h0, 1'b0, 99);

      // start re-asserted in cycles 3-8 changes nothing.
      run_tab("restart", 12, 10, 16'h01F9, 16'h0000, 99, 99, 4'h0, 1'b0, 99);

      // Row 2 empty: first pop[2] in cycle 4, err from cycle 5 and held after done.
      run_tab("err", 12, 10, 16'h0001, 16'h0000, 99, 99, 4'h4, 1'b0, 5);
      // err still set while start is sampled, cleared from cycle 1.
      run_tab("err_clr", 12, 10, 16'h0001, 16'h0000, 99, 99, 4'h0, 1'b1, 99);

      // Reset in cycle 4 mid-run, then idle, then a full run.
      run_tab("midrst", 5, 10, 16'h0001, 16'h0000, 99, 4, 4'h0, 1'b0, 99);
      step("midrst c5", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      step("midrst c6", 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      run_tab("post_rst", 12, 10, 16'h0001, 16'h0000, 99, 99, 4'h0, 1'b0, 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
